// File: rtl/subs_layer_seq.sv
// Time-multiplexed PRESENT S-box layer (forward or inverse).
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data/in_inverse
// accept a block; out_valid/out_ready/out_data return it; busy = RUN|DONE.
module subs_layer_seq #(
    parameter int WIDTH = 64,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inverse,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    // Guarded copy so a bad LANES still elaborates far enough to report.
    localparam int LANES_C = (LANES < 1) ? 1 : LANES;
    localparam int G       = WIDTH / (4 * LANES_C);
    localparam int CW      = (G > 1) ? $clog2(G) : 1;
    localparam logic [CW-1:0] G_LAST = CW'(G - 1);

    if ((LANES < 1) || (WIDTH % (4 * LANES_C) != 0)) begin : g_param_err
        $error("subs_layer_seq: WIDTH must be a multiple of 4*LANES, LANES>=1");
    end

    // Nibble i of each table is S(i).
    localparam logic [63:0] FWD_TAB = 64'h21748FE3DA09B65C;
    localparam logic [63:0] INV_TAB = 64'hA970364BD21C8FE5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [CW-1:0]    cnt_q;
    logic             mode_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             busy_q;
    logic             accept;

    function automatic logic [3:0] sbox(input logic [3:0] x, input logic inv);
        logic [63:0] tab;
        tab = inv ? INV_TAB : FWD_TAB;
        return tab[{x, 2'b00} +: 4];
    endfunction

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

    // Substitute the current group in place; other nibbles pass through.
    always_comb begin
        work_d = work_q;
        for (int l = 0; l < LANES_C; l++) begin
            work_d[(int'(cnt_q) * LANES_C + l) * 4 +: 4] =
                sbox(work_q[(int'(cnt_q) * LANES_C + l) * 4 +: 4], mode_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        work_q  <= in_data;
                        mode_q  <= in_inverse;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    if (cnt_q == G_LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= work_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        // Output handshake and next accept share this edge.
                        if (in_valid) begin
                            work_q  <= in_data;
                            mode_q  <= in_inverse;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/subs_layer_seq.md
Name: subs_layer_seq

Overview:
- Parametrised, time-multiplexed successor to the 64-bit combinational substitution layer.
- Applies the 4-bit PRESENT S-box, or its inverse, to every nibble of a WIDTH-bit state, LANES nibbles per clock.
- Uses a valid/ready handshake on input and output.
- Sits between the key-mix and permutation stages of the round datapath.
- LANES trades area against latency; the inverse mode serves the decryption path.

Parameters:
- WIDTH, 64, state width in bits; must be a multiple of 4*LANES.
- LANES, 4, S-box instances used per cycle; range 1 to WIDTH/4.
- Derived: G = WIDTH/(4*LANES), the number of compute cycles per block.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data and in_inverse are valid.
- in_ready  out  1  block can accept a new state this cycle.
- in_data  in  WIDTH  state to substitute.
- in_inverse  in  1  0 = forward S-box, 1 = inverse S-box; sampled at accept.
- out_valid  out  1  out_data holds the finished result.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  substituted state.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, work register=0, group counter=0, mode=0.
  - Outputs: out_valid=0, out_data=0, busy=0.
  - in_ready is combinational and reads 1 in IDLE.
  - Reset mid-RUN or mid-DONE discards the block and emits no output.
- Forward S-box, inputs 0..F: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
- Inverse S-box, inputs 0..F: 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A.
- FSM IDLE -> RUN -> DONE -> IDLE.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept (in_valid & in_ready):
  - Latch in_data into the work register and in_inverse into mode.
  - Clear the counter and enter RUN.
  - Accept from DONE with out_ready: the output handshake and the new accept occur in the same cycle. This gives back-to-back throughput of one block per G+1 cycles.
- RUN:
  - Each cycle substitutes nibbles cnt*LANES through cnt*LANES+LANES-1 in place. Nibble 0 is bits [3:0], so group 0 is the least-significant nibbles.
  - All other nibbles hold.
  - cnt increments each cycle. When cnt==G-1, the last group is written and the state moves to DONE.
  - Input changes are ignored (in_ready=0).
- DONE:
  - out_valid=1 and out_data = work register.
  - Both are held stable while out_ready=0. No loss and no change under backpressure.
  - out_ready=1 with no new accept: return to IDLE, out_valid=0 next cycle.
- Latency: out_valid rises exactly G cycles after the accept edge (G=4 at defaults). G=1 (LANES=WIDTH/4) gives a single-cycle compute.
- Mode is fixed per block. Toggling in_inverse during RUN or DONE has no effect.
- in_valid while busy and not in_ready: the input is not consumed. The source must hold it.
- Parameter violation (WIDTH % (4*LANES) != 0, or LANES<1): elaboration-time error.
- No X on outputs after the first reset cycle.

Test Plan:
- Reset, then in_data=64'h0, forward, out_ready=1 -> out_valid high 4 cycles after accept, out_data=64'hCCCCCCCCCCCCCCCC, in_ready back to 1 the next cycle.
- in_data=64'h0123456789ABCDEF, forward -> 64'hC56B90AD3EF84712. Feed that result back with in_inverse=1 -> 64'h0123456789ABCDEF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored. Raise out_ready together with a new in_valid -> both handshakes occur that cycle and the second result follows 4 cycles later.
- Reset asserted during RUN at cnt=2 -> next cycle out_valid=0, busy=0, in_ready=1, no output emitted. A subsequent block computes correctly.
- Parameter sweep with WIDTH=64, LANES in {1,2,4,16} -> latency of {16,8,4,1} cycles, identical results to the reference model for 1000 random inputs in both modes.
- Toggle in_inverse every cycle during RUN after a forward accept -> result equals the forward substitution.
